adc_spi_reader: RTL and testbench

Serial ADC read master for the acquisition front end. While `start` is high, it repeatedly frames conversions: it drives `cs_n` low, generates `sck` from `clk_100` and shifts in 16 bits MSB-first from `mdi`. After each frame it presents the word on `adc_data` with a one-cycle `en` strobe. It is the receiving end of the serial link that the ADC imitator drives in simulation, and it drives a real serial ADC in hardware.

---
 rtl/adc_pkg.sv | 19 +
 rtl/adc_sck_gen.sv | 45 ++++
 rtl/adc_spi_reader.sv | 124 ++++++++++++
 tb/tb_adc_spi_reader.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the serial ADC link: frame state encoding and default
// timing constants, used by the reader RTL and by the ADC imitator model.
package adc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_DONE,
      ST_GAP
   } adc_state_t;

   localparam int ADC_SCK_HALF   = 2;
   localparam int ADC_FRAME_BITS = 16;
   localparam int ADC_CS_SETUP   = 2;
   localparam int ADC_CS_GAP     = 4;
   localparam int ADC_WORD_W     = 16;

endpackage

// File: rtl/adc_sck_gen.sv
// Serial clock generator: half-period divider, sck toggle and bit counter.
// Cleared whenever the frame controller is not going to be shifting next cycle.
module adc_sck_gen
   import adc_pkg::*;
#(
   parameter int SCK_HALF   = ADC_SCK_HALF,
   parameter int FRAME_BITS = ADC_FRAME_BITS
) (
   input  logic clk_100,
   input  logic reset,
   input  logic run,
   input  logic clear,
   output logic sck,
   output logic sample,
   output logic last_bit
);

   logic [7:0] half_cnt;
   logic [4:0] bit_cnt;
   logic       half_end;

   assign half_end = run && (half_cnt == 8'(SCK_HALF - 1));
   // The edge that ends a high phase is the falling sck edge: data is taken there.
   assign sample   = half_end && sck;
   assign last_bit = (bit_cnt == 5'(FRAME_BITS - 1));

   always_ff @(posedge clk_100) begin
      if (reset || clear) begin
         half_cnt <= '0;
         bit_cnt  <= '0;
         sck      <= 1'b0;
      end else if (run) begin
         if (half_end) begin
            half_cnt <= '0;
            sck      <= ~sck;
            if (sck) begin
               bit_cnt <= bit_cnt + 5'd1;
            end
         end else begin
            half_cnt <= half_cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/adc_spi_reader.sv
// Serial ADC read master: frames conversions with cs_n/sck while start is high
// and presents each received word on adc_data with a one-cycle en strobe.
module adc_spi_reader
   import adc_pkg::*;
#(
   parameter int SCK_HALF   = ADC_SCK_HALF,
   parameter int FRAME_BITS = ADC_FRAME_BITS,
   parameter int CS_SETUP   = ADC_CS_SETUP,
   parameter int CS_GAP     = ADC_CS_GAP
) (
   input  logic                  clk_100,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  mdi,
   output logic                  sck,
   output logic                  cs_n,
   output logic                  en,
   output logic [ADC_WORD_W-1:0] adc_data,
   output logic                  busy
);

   adc_state_t            state;
   adc_state_t            state_nxt;
   logic [7:0]            phase_cnt;
   logic                  phase_end;
   logic [ADC_WORD_W-2:0] shift_reg;
   logic [ADC_WORD_W-1:0] shift_nxt;
   logic                  sample;
   logic                  last_bit;
   logic                  gen_run;
   logic                  gen_clear;

   // Bits above the frame width always read as zero.
   function automatic logic [ADC_WORD_W-1:0] frame_mask(input logic [ADC_WORD_W-1:0] word);
      logic [ADC_WORD_W-1:0] masked;
      for (int i = 0; i < ADC_WORD_W; i++) begin
         masked[i] = (i < FRAME_BITS) ? word[i] : 1'b0;
      end
      return masked;
   endfunction

   assign shift_nxt = {shift_reg, mdi};
   assign gen_run   = (state == ST_SHIFT);
   assign gen_clear = (state_nxt != ST_SHIFT);

   adc_sck_gen #(
      .SCK_HALF   (SCK_HALF),
      .FRAME_BITS (FRAME_BITS)
   ) u_sck_gen (
      .clk_100  (clk_100),
      .reset    (reset),
      .run      (gen_run),
      .clear    (gen_clear),
      .sck      (sck),
      .sample   (sample),
      .last_bit (last_bit)
   );

   always_comb begin
      phase_end = 1'b0;
      case (state)
         ST_SETUP: phase_end = (phase_cnt == 8'(CS_SETUP - 1));
         ST_GAP:   phase_end = (phase_cnt == 8'(CS_GAP - 1));
         default:  phase_end = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_SETUP;
         ST_SETUP: begin
            if (!start)         state_nxt = ST_IDLE;
            else if (phase_end) state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (!start)                   state_nxt = ST_IDLE;
            else if (sample && last_bit)  state_nxt = ST_DONE;
         end
         ST_DONE:  state_nxt = ST_GAP;
         ST_GAP:   if (phase_end) state_nxt = start ? ST_SETUP : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Control registers: outputs are decoded from the next state so they line up with it.
   always_ff @(posedge clk_100) begin
      if (reset) begin
         state     <= ST_IDLE;
         phase_cnt <= '0;
         cs_n      <= 1'b1;
         en        <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state <= state_nxt;
         if ((state_nxt == state) && ((state == ST_SETUP) || (state == ST_GAP))) begin
            phase_cnt <= phase_cnt + 8'd1;
         end else begin
            phase_cnt <= '0;
         end
         cs_n <= !((state_nxt == ST_SETUP) || (state_nxt == ST_SHIFT));
         en   <= (state_nxt == ST_DONE);
         busy <= (state_nxt == ST_SETUP) || (state_nxt == ST_SHIFT) || (state_nxt == ST_DONE);
      end
   end

   // Data path: shift register and output word, loaded together with the last sample.
   always_ff @(posedge clk_100) begin
      if (state == ST_SETUP) begin
         shift_reg <= '0;
      end else if (sample) begin
         shift_reg <= shift_nxt[ADC_WORD_W-2:0];
      end
   end

   always_ff @(posedge clk_100) begin
      if (reset) begin
         adc_data <= '0;
      end else if ((state == ST_SHIFT) && (state_nxt == ST_DONE)) begin
         adc_data <= frame_mask(shift_nxt);
      end
   end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: ADC imitator models drive mdi, vector table for one
// full default frame, then hand-written sequences for ramp, abort, reset and 12-bit cases.
module tb_adc_spi_reader;

   logic        clk_100 = 1'b0;
   always #5 clk_100 = ~clk_100;

   logic        reset, start, start2;
   logic        mdi  = 1'b0;
   logic        mdi2 = 1'b0;
   logic        sck, cs_n, en, busy;
   logic [15:0] adc_data;
   logic        sck2, cs_n2, en2, busy2;
   logic [15:0] adc_data2;

   int cyc = 0;
   always @(posedge clk_100) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int e0 = 0;
   int rel = 0;

   adc_spi_reader dut (
      .clk_100  (clk_100),
      .reset    (reset),
      .start    (start),
      .mdi      (mdi),
      .sck      (sck),
      .cs_n     (cs_n),
      .en       (en),
      .adc_data (adc_data),
      .busy     (busy)
   );

   adc_spi_reader #(.SCK_HALF(1), .FRAME_BITS(12), .CS_SETUP(2), .CS_GAP(4)) dut2 (
      .clk_100  (clk_100),
      .reset    (reset),
      .start    (start2),
      .mdi      (mdi2),
      .sck      (sck2),
      .cs_n     (cs_n2),
      .en       (en2),
      .adc_data (adc_data2),
      .busy     (busy2)
   );

   // ADC imitators: load word on cs_n fall, present next bit MSB-first just after each sck rise.
   logic [15:0] m1_word = 16'h0;
   logic [15:0] m1_cur  = 16'h0;
   bit          m1_ramp = 1'b0;
   int          m1_rises = 0;
   always @(negedge cs_n or posedge sck) begin
      if (sck) begin
         #1;
         mdi      = m1_cur[15];
         m1_cur   = m1_cur << 1;
         m1_rises = m1_rises + 1;
      end else begin
         m1_cur   = m1_word;
         m1_rises = 0;
         if (m1_ramp) m1_word = m1_word + 16'd1;
      end
   end

   logic [11:0] m2_word = 12'h0;
   logic [11:0] m2_cur  = 12'h0;
   always @(negedge cs_n2 or posedge sck2) begin
      if (sck2) begin
         #1;
         mdi2   = m2_cur[11];
         m2_cur = m2_cur << 1;
      end else begin
         m2_cur = m2_word;
      end
   end

   typedef struct {
      int          cyc;
      logic        cs_n;
      logic        sck;
      logic        en;
      logic        busy;
      logic [15:0] data;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_100);
      rel = cyc - e0;
   endtask

   task automatic wait_en(input bit which, input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         step();
         if ((which == 1'b0 && en) || (which == 1'b1 && en2)) begin
            at = rel;
            break;
         end
      end
   endtask

   initial begin
      int lowcnt, rises_done, at, n, min_gap, hi_run, en_cnt;
      bit prev_en, dbl;
      int en_at[3];
      logic [15:0] en_val[3];

      //           cyc  cs_n  sck   en    busy  data
      vecs[0]  = '{0,  1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[1]  = '{1,  1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
      vecs[2]  = '{2,  1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
      vecs[3]  = '{3,  1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
      vecs[4]  = '{4,  1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
      vecs[5]  = '{5,  1'b0, 1'b1, 1'b0, 1'b1, 16'h0000};
      vecs[6]  = '{7,  1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
      vecs[7]  = '{65, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000};
      vecs[8]  = '{66, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000};
      vecs[9]  = '{67, 1'b1, 1'b0, 1'b1, 1'b1, 16'hA5C3};
      vecs[10] = '{68, 1'b1, 1'b0, 1'b0, 1'b0, 16'hA5C3};
      vecs[11] = '{71, 1'b1, 1'b0, 1'b0, 1'b0, 16'hA5C3};
      vecs[12] = '{72, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA5C3};

      reset  = 1'b1;
      start  = 1'b0;
      start2 = 1'b0;
      repeat (3) @(negedge clk_100);
      check("reset cs_n", 32'(cs_n), 32'd1);
      check("reset sck", 32'(sck), 32'd0);
      check("reset en", 32'(en), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset adc_data", 32'(adc_data), 32'h0);
      check("reset cs_n2", 32'(cs_n2), 32'd1);
      reset = 1'b0;
      repeat (3) @(negedge clk_100);

      // Single frame of 0xA5C3 against the vector table.
      m1_word = 16'hA5C3;
      start = 1'b1;
      e0 = cyc;
      rel = 0;
      lowcnt = 0;
      rises_done = -1;
      for (int i = 0; i < 13; i++) begin
         while (rel < vecs[i].cyc) begin
            step();
            if (rel >= 1 && rel <= 66 && !cs_n) lowcnt++;
            if (rel == 67) rises_done = m1_rises;
         end
         check($sformatf("vec%0d cs_n", i), 32'(cs_n), 32'(vecs[i].cs_n));
         check($sformatf("vec%0d sck", i), 32'(sck), 32'(vecs[i].sck));
         check($sformatf("vec%0d en", i), 32'(en), 32'(vecs[i].en));
         check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
         check($sformatf("vec%0d adc_data", i), 32'(adc_data), 32'(vecs[i].data));
      end
      check("frame cs_n low cycles", lowcnt, 66);
      check("frame sck rises", rises_done, 16);

      // Continuous acquisition with a ramping ADC.
      start = 1'b0;
      repeat (10) step();
      m1_word = 16'h0;
      m1_ramp = 1'b1;
      start = 1'b1;
      e0 = cyc;
      rel = 0;
      n = 0;
      prev_en = 1'b0;
      dbl = 1'b0;
      hi_run = 0;
      min_gap = 1000;
      for (int i = 0; i < 3; i++) begin
         en_at[i] = -1;
         en_val[i] = 16'hFFFF;
      end
      for (int i = 0; i < 250 && n < 3; i++) begin
         step();
         if (en) begin
            if (prev_en) dbl = 1'b1;
            en_at[n] = rel;
            en_val[n] = adc_data;
            n++;
         end
         prev_en = en;
         if (cs_n) begin
            hi_run++;
         end else begin
            if (hi_run > 0 && rel > 1 && hi_run < min_gap) min_gap = hi_run;
            hi_run = 0;
         end
      end
      for (int f = 0; f < 3; f++) begin
         check($sformatf("ramp en cycle %0d", f), en_at[f], 67 + 71 * f);
         check($sformatf("ramp data %0d", f), 32'(en_val[f]), f);
      end
      check("ramp en back-to-back", 32'(dbl), 32'd0);
      check("ramp cs_n gap >= 5", 32'(min_gap >= 5), 32'd1);
      start = 1'b0;
      m1_ramp = 1'b0;
      repeat (20) step();
      check("ramp hold", 32'(adc_data), 32'h2);

      // Abort mid-SHIFT.
      m1_word = 16'h1234;
      start = 1'b1;
      e0 = cyc;
      rel = 0;
      while (rel < 30) step();
      check("abort cs_n before drop", 32'(cs_n), 32'd0);
      start = 1'b0;
      step();
      check("abort cs_n", 32'(cs_n), 32'd1);
      check("abort sck", 32'(sck), 32'd0);
      check("abort busy", 32'(busy), 32'd0);
      check("abort adc_data", 32'(adc_data), 32'h2);
      en_cnt = 0;
      repeat (60) begin
         step();
         if (en) en_cnt++;
      end
      check("abort no en", en_cnt, 0);
      check("abort hold", 32'(adc_data), 32'h2);
      start = 1'b1;
      e0 = cyc;
      rel = 0;
      wait_en(1'b0, 100, at);
      check("restart en cycle", at, 67);
      check("restart data", 32'(adc_data), 32'h1234);
      start = 1'b0;
      repeat (10) step();

      // Reset pulse mid-frame, then recovery with start still high.
      m1_word = 16'h0F0F;
      start = 1'b1;
      e0 = cyc;
      rel = 0;
      while (rel < 40) step();
      reset = 1'b1;
      step();
      check("midreset cs_n", 32'(cs_n), 32'd1);
      check("midreset sck", 32'(sck), 32'd0);
      check("midreset adc_data", 32'(adc_data), 32'h0);
      check("midreset busy", 32'(busy), 32'd0);
      check("midreset en", 32'(en), 32'd0);
      reset = 1'b0;
      wait_en(1'b0, 150, at);
      check("post-reset en cycle", at, 108);
      check("post-reset data", 32'(adc_data), 32'h0F0F);

      // start dropped during DONE: GAP then IDLE, no new frame.
      start = 1'b0;
      step();
      check("done-drop en", 32'(en), 32'd0);
      check("done-drop busy", 32'(busy), 32'd0);
      check("done-drop cs_n", 32'(cs_n), 32'd1);
      lowcnt = 0;
      en_cnt = 0;
      repeat (80) begin
         step();
         if (!cs_n) lowcnt++;
         if (en) en_cnt++;
      end
      check("done-drop no cs_n fall", lowcnt, 0);
      check("done-drop no en", en_cnt, 0);
      check("done-drop hold", 32'(adc_data), 32'h0F0F);

      // SCK_HALF=1, FRAME_BITS=12 instance.
      m2_word = 12'hFFF;
      start2 = 1'b1;
      e0 = cyc;
      rel = 0;
      while (rel < 26) step();
      check("b12 en before", 32'(en2), 32'd0);
      step();
      check("b12 en", 32'(en2), 32'd1);
      check("b12 data", 32'(adc_data2), 32'h0FFF);
      check("b12 cs_n", 32'(cs_n2), 32'd1);
      start2 = 1'b0;
      step();
      check("b12 en after", 32'(en2), 32'd0);
      repeat (10) step();
      m2_word = 12'h9C5;
      start2 = 1'b1;
      e0 = cyc;
      rel = 0;
      wait_en(1'b1, 60, at);
      check("b12 second en cycle", at, 27);
      check("b12 second data", 32'(adc_data2), 32'h09C5);
      start2 = 1'b0;
      repeat (5) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
